// File: rtl/frame_pattern_chk.sv
// frame_pattern_chk
//   Receive-side checker for a fval/lval/dval/pix_value video stream. It
//   measures frame geometry, compares each valid pixel against the pattern
//   selected by sel, flags protocol violations, and publishes per-frame
//   status in a REPORT cycle after fval falls.
// Ports
//   clk, rst_n         clock, async active-low reset
//   sel[2:0]           pattern select (latched on fval rise)
//   fval/lval/dval     frame / line / pixel valid
//   pix_value[7:0]     pixel data
//   frame_done         1-cycle pulse when status outputs update
//   frame_ok           geometry ok, no pixel errors, no protocol errors
//   pix_err_cnt        mismatching pixels in last frame (saturating)
//   geom_err           bad line length or bad line count in last frame
//   proto_err          dval without lval, or lval without fval
//   meas_width         pixel count of the final line of last frame
//   meas_height        completed lines in last frame
//   frame_cnt          frames completed since reset (wraps)
module frame_pattern_chk #(
  parameter int DVAL_HIGH = 640,
  parameter int ROW_COUNT = 480,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       sel,
  input  logic             fval,
  input  logic             lval,
  input  logic             dval,
  input  logic [7:0]       pix_value,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [CNT_W-1:0] pix_err_cnt,
  output logic             geom_err,
  output logic             proto_err,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_height,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [CNT_W-1:0] W_C    = CNT_W'(DVAL_HIGH);
  localparam logic [CNT_W-1:0] H_C    = CNT_W'(ROW_COUNT);
  localparam logic [CNT_W-1:0] CELL_W = CNT_W'(DVAL_HIGH / 8);
  localparam logic [CNT_W-1:0] CELL_H = CNT_W'(ROW_COUNT / 8);
  localparam logic [CNT_W-1:0] ONES   = '1;

  typedef enum logic [1:0] {IDLE, FRAME, LINE, REPORT} state_t;

  state_t           state;
  logic             fval_q, lval_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] x, y, pix_cnt, last_w;
  logic             geom_f, proto_f;

  logic fval_rise, fval_fall, lval_rise, lval_fall;
  logic active, proto_hit, pix_in, close_line, mismatch, cmp_en, chk_odd;
  logic [7:0] exp_pix;

  // Previous levels reset high: a level already asserted at reset release
  // must not look like a rising edge.
  assign fval_rise = fval & ~fval_q;
  assign fval_fall = ~fval & fval_q;
  assign lval_rise = lval & ~lval_q;
  assign lval_fall = ~lval & lval_q;

  assign active     = (state == FRAME) || (state == LINE);
  assign proto_hit  = active && ((dval && !lval) || (lval && !fval));
  // A protocol-violating pixel is neither compared nor counted.
  assign pix_in     = (state == LINE) && dval && lval && fval;
  // fval falling inside a line closes that line, whether or not lval fell too.
  assign close_line = (state == LINE) && (lval_fall || fval_fall);

  assign chk_odd = |(((x / CELL_W) ^ (y / CELL_H)) & CNT_W'(1));

  always_comb begin
    cmp_en  = 1'b1;
    exp_pix = 8'h00;
    case (sel_q)
      3'b000:  exp_pix = 8'h00;
      3'b001:  exp_pix = 8'hFF;
      3'b011:  exp_pix = chk_odd ? 8'hFF : 8'h00;
      default: cmp_en  = 1'b0;
    endcase
  end

  assign mismatch = pix_in && cmp_en && (pix_value != exp_pix);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fval_q      <= 1'b1;
      lval_q      <= 1'b1;
      sel_q       <= '0;
      x           <= '0;
      y           <= '0;
      pix_cnt     <= '0;
      last_w      <= '0;
      geom_f      <= 1'b0;
      proto_f     <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      pix_err_cnt <= '0;
      geom_err    <= 1'b0;
      proto_err   <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      frame_cnt   <= '0;
    end else begin
      fval_q     <= fval;
      lval_q     <= lval;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fval_rise) begin
            sel_q   <= sel;
            x       <= '0;
            y       <= '0;
            pix_cnt <= '0;
            last_w  <= '0;
            geom_f  <= 1'b0;
            proto_f <= 1'b0;
            state   <= FRAME;
          end
        end
        FRAME, LINE: begin
          if (proto_hit) proto_f <= 1'b1;
          if (mismatch && pix_cnt != ONES) pix_cnt <= pix_cnt + 1'b1;
          if (pix_in && x != ONES) x <= x + 1'b1;
          if (close_line) begin
            if (y != ONES) y <= y + 1'b1;
            last_w <= x;
            if (x != W_C) geom_f <= 1'b1;
          end
          if (fval_fall)
            state <= REPORT;
          else if (state == FRAME && lval_rise) begin
            x     <= '0;
            state <= LINE;
          end else if (close_line)
            state <= FRAME;
        end
        REPORT: begin
          frame_done  <= 1'b1;
          pix_err_cnt <= pix_cnt;
          geom_err    <= geom_f || (y != H_C);
          proto_err   <= proto_f;
          frame_ok    <= !geom_f && (y == H_C) && !proto_f && (pix_cnt == '0);
          meas_width  <= last_w;
          meas_height <= y;
          frame_cnt   <= frame_cnt + 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
